// File: rtl/norm_pkg.sv
// Shared defaults, FSM state type and element indexing for the
// perspective-normalization stage.
package norm_pkg;

    localparam int unsigned FRAC_DEF = 8;
    localparam int unsigned DW_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    // Element e (0..11) walks v1.X, v1.Y, v1.Z, v2.X, ... v4.Z
    function automatic logic [1:0] elem_vtx(input logic [3:0] e);
        return 2'(e / 4'd3);
    endfunction

    function automatic logic [1:0] elem_cmp(input logic [3:0] e);
        return 2'(e % 4'd3);
    endfunction

endpackage

// File: rtl/norm_div_serial.sv
// Fixed-latency unsigned restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge so done arrives DW+FRAC
// cycles after the start pulse.
module norm_div_serial #(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               start,
    input  logic [DW+FRAC:0]   dividend,
    input  logic [DW:0]        divisor,
    output logic               done,
    output logic [DW+FRAC:0]   quotient
);

    localparam int unsigned NB = DW + FRAC;
    localparam int unsigned CW = $clog2(NB + 1);

    logic [DW:0]   rem;
    logic [NB-1:0] qr;
    logic [CW-1:0] cnt;
    logic          run;

    logic [DW:0]   src_rem, nrem;
    logic [NB-1:0] src_q, nq;
    logic [DW+1:0] trial, diff;

    // One restoring step; on start it seeds from the new operands.
    // The dividend MSB seeds the remainder: it is zero for every legal
    // magnitude (<= 2^(DW-1)), so NB iterations cover the quotient.
    always_comb begin
        src_rem = start ? {{DW{1'b0}}, dividend[NB]} : rem;
        src_q   = start ? dividend[NB-1:0] : qr;
        trial   = {src_rem, src_q[NB-1]};
        diff    = trial - {1'b0, divisor};
        if (trial >= {1'b0, divisor}) begin
            nrem = diff[DW:0];
            nq   = {src_q[NB-2:0], 1'b1};
        end else begin
            nrem = trial[DW:0];
            nq   = {src_q[NB-2:0], 1'b0};
        end
    end

    // Iteration counter, remainder/quotient registers and done pulse
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rem  <= '0;
            qr   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem <= nrem;
                qr  <= nq;
                cnt <= CW'(NB - 1);
                run <= 1'b1;
            end else if (run) begin
                rem <= nrem;
                qr  <= nq;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = {1'b0, qr};

endmodule

// File: rtl/norm_div_sched.sv
// Perspective-normalization sequencer: divides X/Y/Z of four vertices by
// their W through one shared serial divider, with sign handling,
// saturation and W == 0 override.
module norm_div_sched
    import norm_pkg::*;
#(
    parameter int unsigned FRAC = FRAC_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [16*DW-1:0]   mat_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [12*DW-1:0]   vtx_out,
    output logic               busy,
    output logic               div_zero
);

    localparam int unsigned NB = DW + FRAC;
    localparam logic [DW-1:0] SATP = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SATN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [NB:0]   LIMN = (NB+1)'(1) << (DW - 1);
    localparam logic [NB:0]   LIMP = LIMN - (NB+1)'(1);

    state_t            state;
    logic [16*DW-1:0]  mat;
    logic [3:0]        e;

    logic [1:0]        vi, ci;
    logic [DW-1:0]     num, den;
    logic [DW:0]       nm, dm, num_mag, den_mag;
    logic              neg, den_zero;
    logic [NB:0]       dividend, qm, qneg;
    logic [DW-1:0]     res;
    logic              start, div_done;

    // Select operands for the current element and form the saturated result
    always_comb begin
        vi       = elem_vtx(e);
        ci       = elem_cmp(e);
        num      = mat[DW*(4*32'(vi) + 32'(ci)) +: DW];
        den      = mat[DW*(4*32'(vi) + 3) +: DW];
        nm       = {num[DW-1], num};
        dm       = {den[DW-1], den};
        num_mag  = num[DW-1] ? (~nm + (DW+1)'(1)) : nm;
        den_mag  = den[DW-1] ? (~dm + (DW+1)'(1)) : dm;
        neg      = num[DW-1] ^ den[DW-1];
        den_zero = (den == '0);
        dividend = {num_mag, {FRAC{1'b0}}};
        qneg     = ~qm + (NB+1)'(1);
        if (den_zero) begin
            if (num == '0)      res = '0;
            else if (num[DW-1]) res = SATN;
            else                res = SATP;
        end else if (neg) begin
            res = (qm > LIMN) ? SATN : qneg[DW-1:0];
        end else begin
            res = (qm > LIMP) ? SATP : qm[DW-1:0];
        end
    end

    assign start     = (state == ISSUE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ISSUE) || (state == WAIT) || (state == STORE);

    norm_div_serial #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_div (
        .CLK      (CLK),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (den_mag),
        .done     (div_done),
        .quotient (qm)
    );

    // Sequencing FSM: capture, issue/wait/store per element, hold result
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mat      <= '0;
            e        <= '0;
            vtx_out  <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mat      <= mat_in;
                        div_zero <= 1'b0;
                        e        <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (div_done) state <= STORE;
                end
                STORE: begin
                    vtx_out[DW*32'(e) +: DW] <= res;
                    if (den_zero) div_zero <= 1'b1;
                    if (e == 4'd11) begin
                        state <= DONE;
                    end else begin
                        e     <= e + 4'd1;
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_div_sched.sv
// Scoreboard bench for norm_div_sched: directed matrices with
// hand-computed normalized vertices, latency and handshake checks.
module tb_norm_div_sched;

    localparam int unsigned LAT = 312;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready, busy, div_zero;
    logic [255:0]  mat_in;
    logic [191:0]  vtx_out;

    norm_div_sched #(
        .FRAC (8),
        .DW   (16)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mat_in    (mat_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vtx_out   (vtx_out),
        .busy      (busy),
        .div_zero  (div_zero)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [191:0] v;
        logic         dz;
        int unsigned  acc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_x;
    bit   seen = 1'b0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Rows packed {W,Z,Y,X}; results packed {Z,Y,X}
    localparam logic [63:0] R1 = {16'h0100, 16'h0040, 16'hFF00, 16'h0180};
    localparam logic [47:0] V1 = {16'h0040, 16'hFF00, 16'h0180};
    localparam logic [255:0] M1 = {R1, R1, R1, R1};
    localparam logic [191:0] E1 = {V1, V1, V1, V1};

    localparam logic [255:0] M2 = {
        {16'hFFFF, 16'h0003, 16'h0100, 16'h8000},
        {16'h0001, 16'h0001, 16'h8000, 16'h7000},
        {16'hFE00, 16'h0000, 16'h0100, 16'h0300},
        {16'h0200, 16'hFF00, 16'h0100, 16'h0300}};
    localparam logic [191:0] E2 = {
        {16'hFD00, 16'h8000, 16'h7FFF},
        {16'h0100, 16'h8000, 16'h7FFF},
        {16'h0000, 16'hFF80, 16'hFE80},
        {16'hFF80, 16'h0080, 16'h0180}};

    localparam logic [255:0] M3 = {
        {16'h4000, 16'h7FFF, 16'hFF80, 16'h0080},
        {16'h0000, 16'h0000, 16'hFFFB, 16'h0005},
        {16'h0100, 16'h0300, 16'h0200, 16'h0100},
        {16'h0003, 16'h0100, 16'hFFFF, 16'h0001}};
    localparam logic [191:0] E3 = {
        {16'h01FF, 16'hFFFE, 16'h0002},
        {16'h0000, 16'h8000, 16'h7FFF},
        {16'h0300, 16'h0200, 16'h0100},
        {16'h5555, 16'hFFAB, 16'h0055}};

    // Monitor: on each new result pop the expectation and compare
    always @(negedge CLK) begin
        if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", vtx_out);
            end else begin
                mon_x = sbq.pop_front();
                for (int k = 0; k < 12; k++)
                    chk($sformatf("slot%0d", k), 192'(vtx_out[16*k +: 16]), 192'(mon_x.v[16*k +: 16]));
                chk("div_zero", 192'(div_zero), 192'(mon_x.dz));
                chk("latency", 192'(cyc - mon_x.acc), 192'(LAT));
                chk("busy_at_done", 192'(busy), 192'(0));
            end
        end
    end

    task automatic send(input logic [255:0] m, input logic [191:0] ev, input logic edz, input bit push);
        int n = 0;
        @(negedge CLK);
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        mat_in   = m;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        if (push) sbq.push_back('{v: ev, dz: edz, acc: cyc});
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic reset_state(input string tag);
        chk({tag, "_in_ready"},  192'(in_ready),  192'(1));
        chk({tag, "_out_valid"}, 192'(out_valid), 192'(0));
        chk({tag, "_busy"},      192'(busy),      192'(0));
        chk({tag, "_div_zero"},  192'(div_zero),  192'(0));
        chk({tag, "_vtx_out"},   vtx_out,         192'(0));
    endtask

    logic [191:0] snap;

    initial begin
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mat_in    = '0;
        rst       = 1'b0;
        repeat (3) @(negedge CLK);
        reset_state("reset");
        rst = 1'b1;

        send(M1, E1, 1'b0, 1'b1);
        chk("busy_after_accept", 192'(busy), 192'(1));
        chk("in_ready_busy", 192'(in_ready), 192'(0));
        drain();
        send(M2, E2, 1'b0, 1'b1);
        drain();
        send(M3, E3, 1'b1, 1'b1);
        drain();

        // Backpressure with in_valid asserted while the result is held
        out_ready = 1'b0;
        send(M1, E1, 1'b0, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_out_valid", 192'(out_valid), 192'(1));
        snap     = vtx_out;
        in_valid = 1'b1;
        mat_in   = M2;
        repeat (50) @(negedge CLK);
        chk("bp_vtx_stable", vtx_out, snap);
        chk("bp_in_ready", 192'(in_ready), 192'(0));
        chk("bp_out_valid_held", 192'(out_valid), 192'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_in_ready_after", 192'(in_ready), 192'(1));
        chk("bp_out_valid_after", 192'(out_valid), 192'(0));
        send(M2, E2, 1'b0, 1'b1);
        drain();

        // Reset asserted mid-run discards the partial transaction
        send(M3, E3, 1'b1, 1'b0);
        repeat (100) @(posedge CLK);
        #2;
        chk("midrun_busy", 192'(busy), 192'(1));
        rst = 1'b0;
        #1;
        reset_state("midrun_reset");
        @(negedge CLK);
        rst = 1'b1;
        send(M1, E1, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
